// File: rtl/riscv_def.sv
// Shared RV32I encodings for the riscv core.
// Holds ALU operation and instruction-format enums, major opcode constants,
// the decoded-control bundle shared by ctl_decode and ctl, and a helper that
// maps funct3 onto the OP/OP-IMM ALU operation.
package riscv_def;

  typedef enum logic [3:0] {
    AluOp_ADD   = 4'd0,
    AluOp_SUB   = 4'd1,
    AluOp_SLL   = 4'd2,
    AluOp_SLT   = 4'd3,
    AluOp_SLTU  = 4'd4,
    AluOp_XOR   = 4'd5,
    AluOp_SRL   = 4'd6,
    AluOp_SRA   = 4'd7,
    AluOp_OR    = 4'd8,
    AluOp_AND   = 4'd9,
    AluOp_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    InstFormat_R = 3'd0,
    InstFormat_I = 3'd1,
    InstFormat_S = 3'd2,
    InstFormat_B = 3'd3,
    InstFormat_U = 3'd4,
    InstFormat_J = 3'd5,
    InstFormat_X = 3'd7
  } inst_format_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]   reg1;
    logic [4:0]   reg2;
    logic [4:0]   regd;
    alu_op_e      aluop;
    inst_format_e fmt;
    logic         undef;
    logic         wreg;
    logic         rmem;
    logic         wmem;
    logic         wbsel;
    logic         pcsel;
    logic         bsel;
  } ctl_t;

  // Base (funct7 = 0000000) ALU mapping shared by OP and OP-IMM.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return AluOp_ADD;
      3'b001:  return AluOp_SLL;
      3'b010:  return AluOp_SLT;
      3'b011:  return AluOp_SLTU;
      3'b100:  return AluOp_XOR;
      3'b101:  return AluOp_SRL;
      3'b110:  return AluOp_OR;
      default: return AluOp_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// Purely combinational RV32I decode.
// Ports:
//   idata : 32-bit instruction word
//   dec   : decoded control bundle (register addresses, ALU op, format, strobes)
module ctl_decode
  import riscv_def::*;
(
  input  logic [31:0] idata,
  output ctl_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = idata[6:0];
  assign f3  = idata[14:12];
  assign f7  = idata[31:25];

  always_comb begin
    dec       = '0;
    dec.aluop = AluOp_ADD;
    dec.fmt   = InstFormat_X;
    dec.undef = 1'b0;

    case (opc)
      OPC_OP: begin
        dec.fmt  = InstFormat_R;
        dec.wreg = 1'b1;
        if (f7 == F7_BASE)
          dec.aluop = alu_from_f3(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)
          dec.aluop = AluOp_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)
          dec.aluop = AluOp_SRA;
        else
          dec.undef = 1'b1;
      end
      OPC_OPIMM: begin
        dec.fmt   = InstFormat_I;
        dec.wreg  = 1'b1;
        dec.bsel  = 1'b1;
        dec.aluop = alu_from_f3(f3);
        // funct7 only qualifies the shift-immediate forms.
        if (f3 == 3'b001 && f7 != F7_BASE)
          dec.undef = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)
            dec.aluop = AluOp_SRA;
          else if (f7 != F7_BASE)
            dec.undef = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.fmt   = InstFormat_I;
        dec.bsel  = 1'b1;
        dec.wreg  = 1'b1;
        dec.rmem  = 1'b1;
        dec.wbsel = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
          dec.undef = 1'b1;
      end
      OPC_STORE: begin
        dec.fmt  = InstFormat_S;
        dec.bsel = 1'b1;
        dec.wmem = 1'b1;
        if (f3[2] || f3 == 3'b011)
          dec.undef = 1'b1;
      end
      OPC_BRANCH: begin
        dec.fmt = InstFormat_B;
        case (f3[2:1])
          2'b00:   dec.aluop = AluOp_SUB;
          2'b10:   dec.aluop = AluOp_SLT;
          2'b11:   dec.aluop = AluOp_SLTU;
          default: dec.undef = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.fmt   = InstFormat_U;
        dec.aluop = AluOp_PASSB;
        dec.bsel  = 1'b1;
        dec.wreg  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.fmt  = InstFormat_U;
        dec.bsel = 1'b1;
        dec.wreg = 1'b1;
      end
      OPC_JAL: begin
        dec.fmt   = InstFormat_J;
        dec.wreg  = 1'b1;
        dec.pcsel = 1'b1;
      end
      OPC_JALR: begin
        dec.fmt   = InstFormat_I;
        dec.bsel  = 1'b1;
        dec.wreg  = 1'b1;
        dec.pcsel = 1'b1;
        if (f3 != 3'b000)
          dec.undef = 1'b1;
      end
      default: dec.undef = 1'b1;
    endcase

    // Compressed/reserved encodings never reach a valid opcode.
    if (idata[1:0] != 2'b11)
      dec.undef = 1'b1;

    // Register fields follow the final format so that undefined
    // instructions report all-zero addresses.
    if (dec.undef) begin
      dec       = '0;
      dec.aluop = AluOp_ADD;
      dec.fmt   = InstFormat_X;
      dec.undef = 1'b1;
    end else begin
      if (dec.fmt != InstFormat_U && dec.fmt != InstFormat_J)
        dec.reg1 = idata[19:15];
      if (dec.fmt == InstFormat_R || dec.fmt == InstFormat_S || dec.fmt == InstFormat_B)
        dec.reg2 = idata[24:20];
      if (dec.fmt != InstFormat_S && dec.fmt != InstFormat_B)
        dec.regd = idata[11:7];
    end
  end

endmodule

// File: rtl/ctl.sv
// RV32I decoder / control unit with a one-cycle registered output.
// Ports:
//   clk, rst (sync, active-low), idata : clock, reset, instruction word
//   reg1/reg2/regd                     : rs1/rs2/rd addresses
//   aluop, inst_format, inst_undef     : ALU op, format, illegal flag
//   wreg, rmem, wmem, wbsel, pcsel, bsel : datapath strobes
module ctl
  import riscv_def::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] idata,
  output logic [4:0]  reg1,
  output logic [4:0]  reg2,
  output logic [4:0]  regd,
  output logic [3:0]  aluop,
  output logic [2:0]  inst_format,
  output logic        inst_undef,
  output logic        wreg,
  output logic        rmem,
  output logic        wmem,
  output logic        wbsel,
  output logic        pcsel,
  output logic        bsel
);

  ctl_t ctl_d;
  ctl_t ctl_q;

  ctl_decode u_decode (
    .idata (idata),
    .dec   (ctl_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) ctl_q <= '0;
    else      ctl_q <= ctl_d;
  end

  assign reg1        = ctl_q.reg1;
  assign reg2        = ctl_q.reg2;
  assign regd        = ctl_q.regd;
  assign aluop       = ctl_q.aluop;
  assign inst_format = ctl_q.fmt;
  assign inst_undef  = ctl_q.undef;
  assign wreg        = ctl_q.wreg;
  assign rmem        = ctl_q.rmem;
  assign wmem        = ctl_q.wmem;
  assign wbsel       = ctl_q.wbsel;
  assign pcsel       = ctl_q.pcsel;
  assign bsel        = ctl_q.bsel;

endmodule

// File: tb/tb_ctl.sv
// Directed bench for ctl: each vector is presented for one clock and the
// registered outputs are compared against hand-decoded expectations.
module tb_ctl;

  logic        clk;
  logic        rst;
  logic [31:0] idata;
  logic [4:0]  reg1, reg2, regd;
  logic [3:0]  aluop;
  logic [2:0]  inst_format;
  logic        inst_undef, wreg, rmem, wmem, wbsel, pcsel, bsel;

  int unsigned n_total;
  int unsigned n_bad;

  ctl dut (
    .clk         (clk),
    .rst         (rst),
    .idata       (idata),
    .reg1        (reg1),
    .reg2        (reg2),
    .regd        (regd),
    .aluop       (aluop),
    .inst_format (inst_format),
    .inst_undef  (inst_undef),
    .wreg        (wreg),
    .rmem        (rmem),
    .wmem        (wmem),
    .wbsel       (wbsel),
    .pcsel       (pcsel),
    .bsel        (bsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected fields: r1 r2 rd alu fmt undef wreg rmem wmem wbsel pcsel bsel
  task automatic check_all(input string name,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [3:0] alu, input logic [2:0] fmt, input logic und,
                           input logic w, input logic rm, input logic wm,
                           input logic wb, input logic pc, input logic bs);
    chk({name, ".reg1"},  32'(reg1),        32'(r1));
    chk({name, ".reg2"},  32'(reg2),        32'(r2));
    chk({name, ".regd"},  32'(regd),        32'(rd));
    chk({name, ".aluop"}, 32'(aluop),       32'(alu));
    chk({name, ".fmt"},   32'(inst_format), 32'(fmt));
    chk({name, ".undef"}, 32'(inst_undef),  32'(und));
    chk({name, ".wreg"},  32'(wreg),        32'(w));
    chk({name, ".rmem"},  32'(rmem),        32'(rm));
    chk({name, ".wmem"},  32'(wmem),        32'(wm));
    chk({name, ".wbsel"}, 32'(wbsel),       32'(wb));
    chk({name, ".pcsel"}, 32'(pcsel),       32'(pc));
    chk({name, ".bsel"},  32'(bsel),        32'(bs));
  endtask

  task automatic apply(input logic [31:0] instr);
    idata = instr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b0;
    idata   = 32'h00A485B3;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    //                               r1  r2  rd  alu fmt und w rm wm wb pc bs
    apply(32'h00A485B3); check_all("add",    9, 10, 11,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(32'h40A485B3); check_all("sub",    9, 10, 11,  1, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(32'h0020C1B3); check_all("xor",    1,  2,  3,  5, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(32'h00812283); check_all("lw",     2,  0,  5,  0, 1, 0, 1, 1, 0, 1, 0, 1);
    apply(32'h00512423); check_all("sw",     2,  5,  0,  0, 2, 0, 0, 0, 1, 0, 0, 1);
    apply(32'h00208463); check_all("beq",    1,  2,  0,  1, 3, 0, 0, 0, 0, 0, 0, 0);
    apply(32'h0020F463); check_all("bgeu",   1,  2,  0,  4, 3, 0, 0, 0, 0, 0, 0, 0);
    apply(32'h40315093); check_all("srai",   2,  0,  1,  7, 1, 0, 1, 0, 0, 0, 0, 1);
    apply(32'h123452B7); check_all("lui",    0,  0,  5, 10, 4, 0, 1, 0, 0, 0, 0, 1);
    apply(32'h00001197); check_all("auipc",  0,  0,  3,  0, 4, 0, 1, 0, 0, 0, 0, 1);
    apply(32'h008000EF); check_all("jal",    0,  0,  1,  0, 5, 0, 1, 0, 0, 0, 1, 0);
    apply(32'h000080E7); check_all("jalr",   1,  0,  1,  0, 1, 0, 1, 0, 0, 0, 1, 1);

    apply(32'hFFFFFFFF); check_all("ill_ff", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    apply(32'h02A485B3); check_all("ill_f7", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    apply(32'h40311093); check_all("ill_slli", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    apply(32'h0020A463); check_all("ill_br", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    apply(32'h000090E7); check_all("ill_jalr", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    apply(32'h00813283); check_all("ill_ld", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    apply(32'h00A485B1); check_all("ill_lsb", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);

    // Recover from an illegal word, then reset mid-stream over a valid ADD.
    apply(32'h00A485B3); check_all("add2",   9, 10, 11,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    apply(32'h00812283); check_all("midrst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    apply(32'h00812283); check_all("lw2",    2,  0,  5,  0, 1, 0, 1, 1, 0, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ctl.md
Name: ctl

Overview:
- RV32I instruction decoder / control unit for the riscv core.
- Takes the 32-bit fetched instruction word `idata`.
- Produces register addresses, ALU operation, instruction format, and datapath control strobes.
- All outputs are registered with one-cycle latency. It sits between fetch and the register file, ALU and memory stage.

Parameters:
- None. All encodings come from the shared package `riscv_def`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `idata`  in  32  instruction word.
- `reg1`  out  5  rs1 address, `idata[19:15]`; 0 for U/J formats.
- `reg2`  out  5  rs2 address, `idata[24:20]`; 0 for I/U/J formats.
- `regd`  out  5  rd address, `idata[11:7]`; 0 for S/B formats.
- `aluop`  out  4  ALU operation (`AluOp_*`).
- `inst_format`  out  3  instruction format (`InstFormat_*`).
- `inst_undef`  out  1  illegal or unsupported instruction.
- `wreg`  out  1  write rd.
- `rmem`  out  1  memory read (loads).
- `wmem`  out  1  memory write (stores).
- `wbsel`  out  1  writeback source: 1 = memory data, 0 = ALU result.
- `pcsel`  out  1  1 = unconditional jump target (JAL/JALR).
- `bsel`  out  1  ALU operand B: 1 = immediate, 0 = rs2.

Behaviour:
- On `rst`=0 at a rising edge, every output goes to 0.
  - `aluop` = `AluOp_ADD` (0).
  - `inst_format` = `InstFormat_R` (0).
  - `inst_undef` = 0.
- Otherwise, each rising edge registers the combinational decode of `idata`. Outputs are valid one cycle after `idata` is presented. The outputs have no hold or enable.
- OP (0110011), format R, `wreg`=1, `bsel`=0:
  - funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: f3 000 SUB, 101 SRA.
  - Any other funct7/f3 combination is undefined.
- OP-IMM (0010011), format I, `wreg`=1, `bsel`=1:
  - Same ALU mapping as OP, with ADDI→ADD.
  - SLLI requires funct7=0000000.
  - f3=101 requires funct7 0000000 (SRL) or 0100000 (SRA).
  - Any other shift-immediate funct7 is undefined.
- LOAD (0000011), format I:
  - ADD, `bsel`=1, `wreg`=1, `rmem`=1, `wbsel`=1.
  - f3 in {000,001,010,100,101}; any other f3 is undefined.
- STORE (0100011), format S:
  - ADD, `bsel`=1, `wmem`=1.
  - f3 in {000,001,010}; any other f3 is undefined.
- BRANCH (1100011), format B, `bsel`=0:
  - BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU.
  - f3 010/011 is undefined.
  - `pcsel`=0; branch resolution is done outside this block.
- LUI (0110111), format U: `aluop`=`AluOp_PASSB`, `bsel`=1, `wreg`=1.
- AUIPC (0010111), format U: ADD, `bsel`=1, `wreg`=1.
- JAL (1101111), format J: ADD, `wreg`=1, `pcsel`=1.
- JALR (1100111), format I:
  - ADD, `bsel`=1, `wreg`=1, `pcsel`=1.
  - f3≠000 is undefined.
- `wreg` is asserted even when rd=0; the register file discards writes to x0.
- Undefined instruction covers any of: an unknown opcode, `idata[1:0]`≠11, or an illegal funct field. It produces:
  - `inst_undef`=1 and `inst_format`=`InstFormat_X`.
  - `aluop`=ADD.
  - `wreg`, `rmem`, `wmem`, `wbsel`, `pcsel`, `bsel` = 0.
  - `reg1`, `reg2`, `regd` = 0.
- A reset asserted mid-stream overrides the decode in the same edge.

Decomposition:
- Package `riscv_def` holds:
  - `AluOp_*`: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - `InstFormat_*`: R=0, I=1, S=2, B=3, U=4, J=5, X=7.
  - Opcode constants `OPC_*`.
- Optional sub-module `ctl_decode`: a purely combinational decode. `ctl` wraps it with the output register.

Test Plan:
- Reset: hold `rst`=0 for 2 cycles with any `idata` → all control outputs 0, `aluop`=0, `inst_format`=R, `inst_undef`=0.
- ADD x11,x9,x10 (0x00A485B3) → one cycle later:
  - `aluop`=ADD, `wreg`=1, `inst_format`=R, `bsel`=0.
  - `reg1`=9, `reg2`=10, `regd`=11.
- SUB x11,x9,x10 (0x40A485B3) → `aluop`=SUB, `wreg`=1, `inst_format`=R, `inst_undef`=0.
- LW x5,8(x2) (0x00812283) → `inst_format`=I, ADD, `bsel`=1, `rmem`=1, `wbsel`=1, `wreg`=1, `reg2`=0, `regd`=5.
- SW x5,8(x2) (0x00512423) then BEQ x1,x2 (0x00208463):
  - SW: `wmem`=1, `wreg`=0, format S, `regd`=0.
  - BEQ: format B, `aluop`=SUB, `pcsel`=0.
- Illegal 0xFFFFFFFF and R-type with funct7=0000001 → `inst_undef`=1, `inst_format`=X, all strobes 0.
- JAL x1 (0x008000EF) → `pcsel`=1, `wreg`=1, format J, `reg1`=`reg2`=0.
